score_text_writer: RTL and testbench

- Writes the text line "MOVES: nnnnn" into the character RAM write port that feeds the on-screen text overlay.
- On a start request it latches a 16-bit binary count and converts it to 5 BCD digits sequentially (shift-add-3).
- It then streams 12 ASCII character codes, one per clock, to consecutive cells of one text row.
- It sits between the game controller, which supplies the move count, and the character RAM that the text-drawing path reads during the frame.

---
 rtl/score_text_writer_pkg.sv | 54 +++++
 rtl/score_text_writer_bin2bcd_seq.sv | 62 ++++++
 rtl/score_text_writer.sv | 141 ++++++++++++++
 tb/tb_score_text_writer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_text_writer_pkg.sv
// -----------------------------------------------------------------------------
// score_text_writer_pkg
// Shared definitions for the score text overlay writer:
//   - text grid geometry (TEXT_COLS x TEXT_ROWS)
//   - character constants (space, ASCII zero) and the "MOVES: " label
//   - writer state encoding
//   - shift-add-3 nibble correction helper used by the BCD converter
// No ports (package).
// -----------------------------------------------------------------------------
package score_text_writer_pkg;

   localparam int TEXT_COLS = 17;
   localparam int TEXT_ROWS = 28;

   localparam logic [6:0] CHAR_SPACE = 7'h20;
   localparam logic [6:0] CHAR_ZERO  = 7'h30;

   // "MOVES: " followed by five digit cells makes one 12-cell line
   localparam int LABEL_LEN = 7;
   localparam int DIGITS    = 5;
   localparam int LINE_LEN  = LABEL_LEN + DIGITS;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   function automatic logic [6:0] label_char(input logic [3:0] idx);
      logic [6:0] c;
      case (idx)
         4'd0:    c = 7'h4D; // M
         4'd1:    c = 7'h4F; // O
         4'd2:    c = 7'h56; // V
         4'd3:    c = 7'h45; // E
         4'd4:    c = 7'h53; // S
         4'd5:    c = 7'h3A; // :
         default: c = CHAR_SPACE;
      endcase
      return c;
   endfunction

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift
   function automatic logic [19:0] bcd_add3(input logic [19:0] bcd);
      logic [19:0] r;
      r = bcd;
      for (int k = 0; k < 5; k++) begin
         if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/score_text_writer_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential 16-bit binary to 5-digit BCD converter (shift-add-3), one bit per
// clock, 16 iterations. Result stays on o bcd until the next start.
// Ports:
//   clk    in   1  clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  load bin and begin conversion (ignored while busy)
//   bin    in  16  binary input, latched on an accepted start
//   busy   out  1  conversion in progress
//   done   out  1  one-cycle pulse, bcd valid from this cycle on
//   bcd    out 20  {d4,d3,d2,d1,d0}
// -----------------------------------------------------------------------------
module bin2bcd_seq
   import score_text_writer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        busy,
   output logic        done,
   output logic [19:0] bcd
);

   logic [15:0] r_bin;
   logic [19:0] r_bcd;
   logic [3:0]  r_cnt;
   logic        r_busy;
   logic        r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (r_busy) begin
         {r_bcd, r_bin} <= {bcd_add3(r_bcd), r_bin} << 1;
         r_cnt          <= r_cnt + 4'd1;
         // counter wraps 15->0 on the last iteration
         if (r_cnt == 4'd15) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_bin  <= bin;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign bcd  = r_bcd;

endmodule

// File: rtl/score_text_writer.sv
// -----------------------------------------------------------------------------
// score_text_writer
// Writes "MOVES: nnnnn" into one row of the character RAM. On start the move
// count is converted to BCD, then 12 characters are written, one per clock, to
// cells {ROW, COL}..{ROW, COL+11}; done pulses one cycle after the last write.
// Optional build macro SCORE_TEXT_BLANK_ZERO_EN: leading zero digits d4..d1
// are written as spaces (d0 always a digit). Timing is the same either way.
// Parameters: ROW (0..27), COL (0..5).
// Ports:
//   pclk     in   1  pixel clock, rising edge
//   rst      in   1  asynchronous active-low reset
//   start    in   1  write request, sampled only when idle
//   value    in  16  binary count, latched on an accepted start
//   busy     out  1  operation in progress
//   done     out  1  one-cycle completion pulse
//   wr_en    out  1  character RAM write strobe
//   wr_yx    out 10  write address {row[4:0], col[4:0]}
//   wr_code  out  7  ASCII code
// -----------------------------------------------------------------------------
module score_text_writer
   import score_text_writer_pkg::*;
#(
   parameter logic [4:0] ROW = 5'd10,
   parameter logic [4:0] COL = 5'd2
)
(
   input  logic        pclk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] value,
   output logic        busy,
   output logic        done,
   output logic        wr_en,
   output logic [9:0]  wr_yx,
   output logic [6:0]  wr_code
);

   localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);

   if ((int'(COL) + LINE_LEN > TEXT_COLS) || (int'(ROW) >= TEXT_ROWS)) begin : g_cfg_check
      $error("score_text_writer: ROW/COL place the line outside the text grid");
   end

   state_t      r_state;
   logic [3:0]  r_idx;

   logic        w_bcd_start;
   logic        w_bcd_busy;
   logic        w_bcd_done;
   logic [19:0] w_bcd;

   function automatic logic [6:0] char_at(input logic [3:0] idx, input logic [19:0] bcd);
      logic [3:0] d;
`ifdef SCORE_TEXT_BLANK_ZERO_EN
      logic       lead;
`endif
      if (idx < 4'(LABEL_LEN)) return label_char(idx);
      case (idx)
         4'd7:    d = bcd[19:16];
         4'd8:    d = bcd[15:12];
         4'd9:    d = bcd[11:8];
         4'd10:   d = bcd[7:4];
         default: d = bcd[3:0];
      endcase
`ifdef SCORE_TEXT_BLANK_ZERO_EN
      // a digit is blank only if it and every more significant digit is zero
      case (idx)
         4'd7:    lead = (bcd[19:16] == 4'd0);
         4'd8:    lead = (bcd[19:12] == 8'd0);
         4'd9:    lead = (bcd[19:8]  == 12'd0);
         4'd10:   lead = (bcd[19:4]  == 16'd0);
         default: lead = 1'b0;
      endcase
      if (lead) return CHAR_SPACE;
`endif
      return CHAR_ZERO + {3'b000, d};
   endfunction

   // The converter latches value directly on the accepting edge
   assign w_bcd_start = (r_state == ST_IDLE) && start && !w_bcd_busy;

   bin2bcd_seq u_bcd (
      .clk   (pclk),
      .rst_n (rst),
      .start (w_bcd_start),
      .bin   (value),
      .busy  (w_bcd_busy),
      .done  (w_bcd_done),
      .bcd   (w_bcd)
   );

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wr_en   <= 1'b0;
         wr_yx   <= '0;
         wr_code <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               wr_en <= 1'b0;
               done  <= 1'b0;
               r_idx <= '0;
               if (w_bcd_start) begin
                  busy    <= 1'b1;
                  r_state <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               // first character goes out on the edge the result is seen
               if (w_bcd_done) begin
                  wr_en   <= 1'b1;
                  wr_yx   <= {ROW, COL};
                  wr_code <= char_at(4'd0, w_bcd);
                  r_idx   <= 4'd1;
                  r_state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               wr_en   <= 1'b1;
               wr_yx   <= {ROW, COL + {1'b0, r_idx}};
               wr_code <= char_at(r_idx, w_bcd);
               r_idx   <= r_idx + 4'd1;
               if (r_idx == LAST_IDX) r_state <= ST_DONE;
            end
            ST_DONE: begin
               wr_en   <= 1'b0;
               done    <= 1'b1;
               busy    <= 1'b0;
               r_idx   <= '0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_score_text_writer.sv
// -----------------------------------------------------------------------------
// tb_score_text_writer
// Self-checking bench for score_text_writer with a cycle-indexed expectation
// table built from the line text and the documented timing.
// -----------------------------------------------------------------------------
module tb_score_text_writer;

   localparam logic [4:0] ROW  = 5'd10;
   localparam logic [4:0] COL  = 5'd2;
   localparam int         MAXC = 128;

   logic        pclk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] value = 16'd0;
   logic        busy;
   logic        done;
   logic        wr_en;
   logic [9:0]  wr_yx;
   logic [6:0]  wr_code;

   always #5 pclk = ~pclk;

   score_text_writer #(.ROW(ROW), .COL(COL)) dut (
      .pclk    (pclk),
      .rst     (rst),
      .start   (start),
      .value   (value),
      .busy    (busy),
      .done    (done),
      .wr_en   (wr_en),
      .wr_yx   (wr_yx),
      .wr_code (wr_code)
   );

   int n_checks = 0;
   int n_err    = 0;

   bit         exp_busy [MAXC];
   bit         exp_done [MAXC];
   bit         exp_wr   [MAXC];
   logic [9:0] exp_yx   [MAXC];
   logic [6:0] exp_code [MAXC];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_plan();
      for (int i = 0; i < MAXC; i++) begin
         exp_busy[i] = 1'b0;
         exp_done[i] = 1'b0;
         exp_wr[i]   = 1'b0;
         exp_yx[i]   = '0;
         exp_code[i] = '0;
      end
   endtask

   // Text of the line for a given count, from decimal arithmetic
   task automatic line_chars(input logic [15:0] v, output logic [6:0] ch [12]);
      string lbl;
      byte   b;
      int    p;
      int    d;
      bit    lead;
      lbl  = "MOVES: ";
      for (int i = 0; i < 7; i++) begin
         b     = lbl[i];
         ch[i] = b[6:0];
      end
      p    = 10000;
      lead = 1'b1;
      for (int k = 0; k < 5; k++) begin
         d = (int'(v) / p) % 10;
         p = p / 10;
`ifdef SCORE_TEXT_BLANK_ZERO_EN
         if (lead && d == 0 && k < 4) begin
            ch[7+k] = 7'h20;
         end else begin
            lead    = 1'b0;
            ch[7+k] = 7'(8'h30 + d);
         end
`else
         lead    = 1'b0;
         ch[7+k] = 7'(8'h30 + d);
`endif
      end
   endtask

   // One run accepted at edge e0: busy e0..e0+28, writes e0+17..e0+28, done e0+29
   task automatic plan_run(input int e0, input logic [15:0] v);
      logic [6:0] ch [12];
      logic [4:0] c;
      line_chars(v, ch);
      for (int e = e0; e <= e0 + 28; e++) exp_busy[e] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         c                 = COL + 5'(i);
         exp_wr[e0+17+i]   = 1'b1;
         exp_yx[e0+17+i]   = {ROW, c};
         exp_code[e0+17+i] = ch[i];
      end
      exp_done[e0+29] = 1'b1;
   endtask

   // mode 0: single start pulse; 1: start pulses and value changes mid-run;
   // 2: start held high through a second run with value v2
   task automatic run(input int ncyc, input int mode, input logic [15:0] v2);
      int nwr;
      int nexp;
      nwr  = 0;
      nexp = 0;
      for (int e = 0; e <= ncyc; e++) begin
         @(posedge pclk);
         #1;
         check($sformatf("wr_en@%0d", e), 32'(wr_en), 32'(exp_wr[e]));
         if (exp_wr[e]) begin
            check($sformatf("wr_yx@%0d", e), 32'(wr_yx), 32'(exp_yx[e]));
            check($sformatf("wr_code@%0d", e), 32'(wr_code), 32'(exp_code[e]));
         end
         check($sformatf("done@%0d", e), 32'(done), 32'(exp_done[e]));
         check($sformatf("busy@%0d", e), 32'(busy), 32'(exp_busy[e]));
         if (wr_en === 1'b1) nwr++;
         if (exp_wr[e]) nexp++;
         case (mode)
            0: if (e == 0) start = 1'b0;
            1: begin
               if (e == 0) begin
                  start = 1'b0;
                  value = 16'($urandom);
               end
               if (e == 4 || e == 19) start = 1'b1;
               if (e == 5 || e == 20) start = 1'b0;
               if (e == 12) value = 16'($urandom);
            end
            default: begin
               if (e == 0)  value = v2;
               if (e == 30) start = 1'b0;
            end
         endcase
      end
      check("write_count", 32'(nwr), 32'(nexp));
   endtask

   task automatic single(input logic [15:0] v, input int mode);
      clear_plan();
      plan_run(0, v);
      @(negedge pclk);
      start = 1'b1;
      value = v;
      run(31, mode, 16'd0);
   endtask

   logic [15:0] rv;
   logic [15:0] rv2;
   int          nwr_after;

   initial begin
      // reset state
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_yx", 32'(wr_yx), 32'd0);
      check("rst_wr_code", 32'(wr_code), 32'd0);
      @(negedge pclk);
      rst = 1'b1;
      repeat (2) @(negedge pclk);

      // directed values and boundaries
      single(16'd42, 0);
      single(16'd65535, 0);
      single(16'd0, 0);
      single(16'd7, 0);
      single(16'd1000, 0);

      // random values
      for (int n = 0; n < 6; n++) begin
         rv = 16'($urandom);
         single(rv, 0);
      end

      // start pulses and value changes during an operation are ignored
      rv = 16'($urandom);
      single(rv, 1);

      // back-to-back with start held high
      rv  = 16'($urandom);
      rv2 = 16'($urandom);
      clear_plan();
      plan_run(0, rv);
      plan_run(30, rv2);
      @(negedge pclk);
      start = 1'b1;
      value = rv;
      run(62, 2, rv2);

      // asynchronous reset during WRITE
      rv = 16'($urandom);
      @(negedge pclk);
      start = 1'b1;
      value = rv;
      @(posedge pclk);
      #1 start = 1'b0;
      repeat (20) @(posedge pclk);
      #1;
      check("pre_rst_wr_en", 32'(wr_en), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_wr_en", 32'(wr_en), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_wr_yx", 32'(wr_yx), 32'd0);
      check("mid_rst_wr_code", 32'(wr_code), 32'd0);
      @(negedge pclk);
      rst = 1'b1;
      nwr_after = 0;
      for (int e = 0; e < 40; e++) begin
         @(posedge pclk);
         #1;
         if (wr_en === 1'b1) nwr_after++;
         check($sformatf("post_rst_busy@%0d", e), 32'(busy), 32'd0);
      end
      check("post_rst_writes", 32'(nwr_after), 32'd0);

      // recovery after reset
      rv = 16'($urandom);
      single(rv, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
